// File: rtl/pong_round_controller.sv
// Round sequencer for the Pong datapath: synchronises the VGA frame strobe and
// the start button, steps the match through serve / play / score / game-over,
// holds the CPU in reset outside of play, keeps the score, and latches the ball
// position once per frame so the display never shows a half-updated position.
module pong_round_controller #(
  parameter int SERVE_FRAMES      = 60,
  parameter int SCORE_HOLD_FRAMES = 90,
  parameter int WIN_SCORE         = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       screenEnd,
  input  logic       start,
  input  logic [1:0] winner,
  input  logic [9:0] ball_x_in,
  input  logic [8:0] ball_y_in,
  output logic       posEdgeScreenEnd,
  output logic       cpu_reset,
  output logic [9:0] disp_ball_x,
  output logic [8:0] disp_ball_y,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic [2:0] state
);

  localparam int CNT_MAX = (SERVE_FRAMES > SCORE_HOLD_FRAMES) ? SERVE_FRAMES : SCORE_HOLD_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SCORE_HOLD_FRAMES - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    SCORE = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] frame_cnt;

  logic se_p0, se_p1, se_p2;
  logic sb_p0, sb_p1, sb_p2;
  logic frame_tick, start_evt;
  logic p1_won, p2_won;
  logic [3:0] p1_next, p2_next;

  // Score increment that pins at the winning score instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    if (s >= WIN) return WIN;
    else          return s + 4'd1;
  endfunction

  assign state      = st;
  assign frame_tick = se_p1 & ~se_p2;
  assign start_evt  = sb_p1 & ~sb_p2;
  // 11 from the regfile is meaningless and treated like "no point scored".
  assign p1_won     = (winner == 2'b01);
  assign p2_won     = (winner == 2'b10);
  assign p1_next    = sat_inc(score_p1);
  assign p2_next    = sat_inc(score_p2);

  // Two-flop synchronisers plus one history flop per input for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      se_p0 <= 1'b0; se_p1 <= 1'b0; se_p2 <= 1'b0;
      sb_p0 <= 1'b0; sb_p1 <= 1'b0; sb_p2 <= 1'b0;
    end else begin
      se_p0 <= screenEnd; se_p1 <= se_p0; se_p2 <= se_p1;
      sb_p0 <= start;     sb_p1 <= sb_p0; sb_p2 <= sb_p1;
    end
  end

  // Game-update pulse: only during play and only when no point was scored this cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) posEdgeScreenEnd <= 1'b0;
    else        posEdgeScreenEnd <= frame_tick && (st == PLAY) && !p1_won && !p2_won;
  end

  // Tear-free display copy of the ball position, refreshed once per frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_ball_x <= '0;
      disp_ball_y <= '0;
    end else if (frame_tick) begin
      disp_ball_x <= ball_x_in;
      disp_ball_y <= ball_y_in;
    end
  end

  // Round state machine with registered control outputs and score keeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st           <= IDLE;
      frame_cnt    <= '0;
      cpu_reset    <= 1'b1;
      match_over   <= 1'b0;
      score_p1     <= 4'd0;
      score_p2     <= 4'd0;
      match_winner <= 2'b00;
    end else begin
      if (frame_tick) frame_cnt <= frame_cnt + CNT_W'(1);
      case (st)
        IDLE: begin
          if (start_evt) begin
            st        <= SERVE;
            frame_cnt <= '0;
          end
        end
        SERVE: begin
          if (frame_tick && frame_cnt == SERVE_LAST) begin
            st        <= PLAY;
            cpu_reset <= 1'b0;
            frame_cnt <= '0;
          end
        end
        PLAY: begin
          // A scored point wins over a frame tick arriving in the same cycle.
          if (p1_won) begin
            score_p1  <= p1_next;
            if (p1_next == WIN) match_winner <= 2'b01;
            st        <= SCORE;
            cpu_reset <= 1'b1;
            frame_cnt <= '0;
          end else if (p2_won) begin
            score_p2  <= p2_next;
            if (p2_next == WIN) match_winner <= 2'b10;
            st        <= SCORE;
            cpu_reset <= 1'b1;
            frame_cnt <= '0;
          end
        end
        SCORE: begin
          if (frame_tick && frame_cnt == HOLD_LAST) begin
            frame_cnt <= '0;
            if (match_winner != 2'b00) begin
              st         <= OVER;
              match_over <= 1'b1;
            end else begin
              st <= SERVE;
            end
          end
        end
        OVER: begin
          if (start_evt) begin
            score_p1     <= 4'd0;
            score_p2     <= 4'd0;
            match_winner <= 2'b00;
            match_over   <= 1'b0;
            st           <= SERVE;
            frame_cnt    <= '0;
          end
        end
        default: begin
          st         <= IDLE;
          cpu_reset  <= 1'b1;
          match_over <= 1'b0;
          frame_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_round_controller.sv
// Bench for pong_round_controller: a directed vector table, a few hand-timed
// sequences around the pulse latency, winner/tick priority and async reset,
// then random frame/start/reset operations against an event-level model.
module tb_pong_round_controller;

  localparam int SERVE_F = 2;
  localparam int HOLD_F  = 1;
  localparam int WIN_S   = 2;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_SCORE = 3, S_OVER = 4;
  localparam int OP_RESET = 0, OP_START = 1, OP_FRAME = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       screenEnd = 1'b0;
  logic       start = 1'b0;
  logic [1:0] winner = 2'b00;
  logic [9:0] ball_x_in = '0;
  logic [8:0] ball_y_in = '0;
  logic       posEdgeScreenEnd;
  logic       cpu_reset;
  logic [9:0] disp_ball_x;
  logic [8:0] disp_ball_y;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       match_over;
  logic [1:0] match_winner;
  logic [2:0] state;

  pong_round_controller #(
    .SERVE_FRAMES(SERVE_F),
    .SCORE_HOLD_FRAMES(HOLD_F),
    .WIN_SCORE(WIN_S)
  ) dut (
    .clock(clock), .reset(reset), .screenEnd(screenEnd), .start(start),
    .winner(winner), .ball_x_in(ball_x_in), .ball_y_in(ball_y_in),
    .posEdgeScreenEnd(posEdgeScreenEnd), .cpu_reset(cpu_reset),
    .disp_ball_x(disp_ball_x), .disp_ball_y(disp_ball_y),
    .score_p1(score_p1), .score_p2(score_p2), .match_over(match_over),
    .match_winner(match_winner), .state(state)
  );

  always #5 clock = ~clock;

  int pulse_cnt = 0;
  always @(negedge clock) if (posEdgeScreenEnd) pulse_cnt <= pulse_cnt + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // ---------------- stimulus operations ----------------
  task automatic do_reset();
    @(negedge clock); reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic do_start();
    @(negedge clock); start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  // Winner is presented for one cycle, then a full screenEnd pulse follows with winner back at 00.
  task automatic do_frame(input int w, input int bx, input int by);
    @(negedge clock);
    ball_x_in = 10'(bx); ball_y_in = 9'(by); winner = 2'(w);
    @(negedge clock);
    winner = 2'b00;
    screenEnd = 1'b1;
    repeat (3) @(negedge clock);
    screenEnd = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic run_op(input int op, input int w, input int bx, input int by);
    case (op)
      OP_RESET: do_reset();
      OP_START: do_start();
      default:  do_frame(w, bx, by);
    endcase
  endtask

  // ---------------- event-level reference model ----------------
  int m_st, m_p1, m_p2, m_mw, m_cnt, m_dx, m_dy;

  task automatic m_reset();
    m_st = S_IDLE; m_p1 = 0; m_p2 = 0; m_mw = 0; m_cnt = 0; m_dx = 0; m_dy = 0;
  endtask

  task automatic m_start();
    if (m_st == S_IDLE) begin
      m_st = S_SERVE; m_cnt = 0;
    end else if (m_st == S_OVER) begin
      m_p1 = 0; m_p2 = 0; m_mw = 0; m_st = S_SERVE; m_cnt = 0;
    end
  endtask

  task automatic m_frame(input int w, input int bx, input int by, output int pulses);
    pulses = 0;
    if (m_st == S_PLAY && (w == 1 || w == 2)) begin
      if (w == 1) begin
        if (m_p1 < WIN_S) m_p1++;
        if (m_p1 == WIN_S) m_mw = 1;
      end else begin
        if (m_p2 < WIN_S) m_p2++;
        if (m_p2 == WIN_S) m_mw = 2;
      end
      m_st = S_SCORE; m_cnt = 0;
    end
    m_dx = bx; m_dy = by;
    if (m_st == S_PLAY) begin
      pulses = 1;
    end else if (m_st == S_SERVE) begin
      m_cnt++;
      if (m_cnt == SERVE_F) begin m_st = S_PLAY; m_cnt = 0; end
    end else if (m_st == S_SCORE) begin
      m_cnt++;
      if (m_cnt == HOLD_F) begin m_st = (m_mw != 0) ? S_OVER : S_SERVE; m_cnt = 0; end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int op; int w; int bx; int by;
    int st; int p1; int p2; int mw; int pulses; int dx; int dy;
  } vec_t;

  vec_t tbl [0:17];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int pulses;
    int r, w;

    //            op        w  bx      by      st       p1 p2 mw pl dx      dy
    tbl[0]  = '{OP_RESET, 0, 0,      0,      S_IDLE,  0, 0, 0, 0, 0,      0};
    tbl[1]  = '{OP_START, 0, 0,      0,      S_SERVE, 0, 0, 0, 0, 0,      0};
    tbl[2]  = '{OP_FRAME, 0, 'h011,  'h022,  S_SERVE, 0, 0, 0, 0, 'h011,  'h022};
    tbl[3]  = '{OP_FRAME, 0, 'h155,  'h0AA,  S_PLAY,  0, 0, 0, 0, 'h155,  'h0AA};
    tbl[4]  = '{OP_FRAME, 0, 'h2AA,  'h155,  S_PLAY,  0, 0, 0, 1, 'h2AA,  'h155};
    tbl[5]  = '{OP_FRAME, 1, 'h100,  'h050,  S_SERVE, 1, 0, 0, 0, 'h100,  'h050};
    tbl[6]  = '{OP_FRAME, 0, 'h3FF,  'h1FF,  S_SERVE, 1, 0, 0, 0, 'h3FF,  'h1FF};
    tbl[7]  = '{OP_FRAME, 0, 'h001,  'h001,  S_PLAY,  1, 0, 0, 0, 'h001,  'h001};
    tbl[8]  = '{OP_FRAME, 2, 'h200,  'h100,  S_SERVE, 1, 1, 0, 0, 'h200,  'h100};
    tbl[9]  = '{OP_FRAME, 0, 'h123,  'h045,  S_SERVE, 1, 1, 0, 0, 'h123,  'h045};
    tbl[10] = '{OP_FRAME, 0, 'h0F0,  'h0F0,  S_PLAY,  1, 1, 0, 0, 'h0F0,  'h0F0};
    tbl[11] = '{OP_FRAME, 2, 'h300,  'h180,  S_OVER,  1, 2, 2, 0, 'h300,  'h180};
    tbl[12] = '{OP_FRAME, 1, 'h0AB,  'h0CD,  S_OVER,  1, 2, 2, 0, 'h0AB,  'h0CD};
    tbl[13] = '{OP_START, 0, 0,      0,      S_SERVE, 0, 0, 0, 0, 'h0AB,  'h0CD};
    tbl[14] = '{OP_FRAME, 3, 'h010,  'h020,  S_SERVE, 0, 0, 0, 0, 'h010,  'h020};
    tbl[15] = '{OP_FRAME, 0, 'h030,  'h040,  S_PLAY,  0, 0, 0, 0, 'h030,  'h040};
    tbl[16] = '{OP_FRAME, 3, 'h050,  'h060,  S_PLAY,  0, 0, 0, 1, 'h050,  'h060};
    tbl[17] = '{OP_START, 0, 0,      0,      S_PLAY,  0, 0, 0, 0, 'h050,  'h060};

    // Reset state straight out of power-up reset.
    repeat (2) @(negedge clock);
    chk("por_state", state, S_IDLE);
    chk("por_cpu_reset", cpu_reset, 1);
    chk("por_pulse", posEdgeScreenEnd, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 18; i++) begin
      p0 = pulse_cnt;
      run_op(tbl[i].op, tbl[i].w, tbl[i].bx, tbl[i].by);
      chk($sformatf("t%0d_state", i), state, tbl[i].st);
      chk($sformatf("t%0d_p1", i), score_p1, tbl[i].p1);
      chk($sformatf("t%0d_p2", i), score_p2, tbl[i].p2);
      chk($sformatf("t%0d_winner", i), match_winner, tbl[i].mw);
      chk($sformatf("t%0d_over", i), match_over, (tbl[i].st == S_OVER) ? 1 : 0);
      chk($sformatf("t%0d_cpu_reset", i), cpu_reset, (tbl[i].st == S_PLAY) ? 0 : 1);
      chk($sformatf("t%0d_pulses", i), pulse_cnt - p0, tbl[i].pulses);
      chk($sformatf("t%0d_disp_x", i), disp_ball_x, tbl[i].dx);
      chk($sformatf("t%0d_disp_y", i), disp_ball_y, tbl[i].dy);
    end

    // Pulse latency: high only after the third edge following screenEnd rising.
    @(negedge clock);
    ball_x_in = 10'h155; ball_y_in = 9'h0AB; screenEnd = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clock);
      chk($sformatf("lat_pulse_e%0d", e), posEdgeScreenEnd, (e == 3) ? 1 : 0);
      if (e == 3) chk("lat_disp_x", disp_ball_x, 'h155);
    end
    screenEnd = 1'b0;
    repeat (4) @(negedge clock);

    // Winner arriving in the same cycle as the frame tick: point scored, no update pulse.
    p0 = pulse_cnt;
    screenEnd = 1'b1;
    @(negedge clock);
    @(negedge clock);
    winner = 2'b01;
    @(negedge clock);
    chk("coin_state", state, S_SCORE);
    chk("coin_p1", score_p1, 1);
    chk("coin_cpu_reset", cpu_reset, 1);
    winner = 2'b00; screenEnd = 1'b0;
    repeat (4) @(negedge clock);
    chk("coin_pulses", pulse_cnt - p0, 0);
    do_frame(0, 'h0AA, 'h055);
    chk("coin_to_serve", state, S_SERVE);
    do_frame(0, 'h0AA, 'h055);
    do_frame(0, 'h0AA, 'h055);
    chk("w11_pre_state", state, S_PLAY);

    // winner=11 held across five frames in play: ignored, five update pulses.
    p0 = pulse_cnt;
    winner = 2'b11;
    for (int f = 0; f < 5; f++) begin
      @(negedge clock); screenEnd = 1'b1;
      repeat (3) @(negedge clock);
      screenEnd = 1'b0;
      repeat (4) @(negedge clock);
    end
    chk("w11_pulses", pulse_cnt - p0, 5);
    chk("w11_state", state, S_PLAY);
    chk("w11_p1", score_p1, 1);
    chk("w11_p2", score_p2, 0);
    winner = 2'b00;

    // Asynchronous reset mid-play takes effect without waiting for a clock edge.
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("areset_state", state, S_IDLE);
    chk("areset_cpu_reset", cpu_reset, 1);
    chk("areset_p1", score_p1, 0);
    chk("areset_disp_x", disp_ball_x, 0);
    chk("areset_disp_y", disp_ball_y, 0);
    chk("areset_winner", match_winner, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    m_reset();

    // Random operations against the model.
    for (int k = 0; k < 150; k++) begin
      int op, bx, by;
      r  = $urandom_range(0, 19);
      bx = $urandom_range(0, 1023);
      by = $urandom_range(0, 511);
      w  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 3);
      op = (r == 0) ? OP_RESET : (r < 5) ? OP_START : OP_FRAME;
      p0 = pulse_cnt;
      run_op(op, w, bx, by);
      pulses = 0;
      case (op)
        OP_RESET: m_reset();
        OP_START: m_start();
        default:  m_frame(w, bx, by, pulses);
      endcase
      chk($sformatf("r%0d_state", k), state, m_st);
      chk($sformatf("r%0d_p1", k), score_p1, m_p1);
      chk($sformatf("r%0d_p2", k), score_p2, m_p2);
      chk($sformatf("r%0d_winner", k), match_winner, m_mw);
      chk($sformatf("r%0d_over", k), match_over, (m_st == S_OVER) ? 1 : 0);
      chk($sformatf("r%0d_cpu_reset", k), cpu_reset, (m_st == S_PLAY) ? 0 : 1);
      chk($sformatf("r%0d_pulses", k), pulse_cnt - p0, pulses);
      chk($sformatf("r%0d_disp_x", k), disp_ball_x, m_dx);
      chk($sformatf("r%0d_disp_y", k), disp_ball_y, m_dy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
